instr_sequencer: RTL
====================

INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-002 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port start  input  1  level-sampled; begins program execution from address 0.
REQ-004 SHALL have port prog_addr  output  4  program memory address (current PC).
REQ-005 SHALL have port prog_data  input  8  program word: [7:4] opcode, [3:0] immediate; combinational read of prog_addr.
REQ-006 SHALL have port instr  output  4  instruction code issued to the register file.
REQ-007 SHALL have port imm  output  4  immediate value presented to the register file.
REQ-008 SHALL have port busy  output  1  high in any state other than IDLE and HALT.
REQ-009 SHALL have port halted  output  1  high only in HALT.

Function
REQ-010 SHALL implement states IDLE, FETCH, DECODE, EXEC, HALT.
REQ-011 IDLE: start=1 -> FETCH with PC=0; otherwise remain.
REQ-012 FETCH (1 cycle): prog_addr=PC; prog_data captured into opcode/imm registers at cycle end; -> DECODE.
REQ-013 DECODE (1 cycle): instr=0; opcode 0xF -> HALT; else -> EXEC.
REQ-014 EXEC (1 cycle): opcodes 0x1-0xD drive instr=opcode for exactly this cycle; opcodes 0x0 (NOP) and 0xE (JMP) drive instr=0; -> FETCH.
REQ-015 imm SHALL hold the captured immediate from DECODE through the end of EXEC and keep it until the next capture.
REQ-016 PC update at end of EXEC: JMP -> PC=imm; otherwise PC=PC+1 modulo 16 (15 wraps to 0, execution continues).
REQ-017 Throughput SHALL be one instruction per 3 cycles; instr valid exactly 2 cycles after the FETCH cycle of that word.
REQ-018 instr SHALL be 0 in every state except EXEC.
REQ-019 start SHALL be ignored while busy=1.
REQ-020 HALT: start=1 -> FETCH with PC=0 (restart); otherwise remain; instr=0.
REQ-021 JMP to its own address SHALL loop indefinitely without error.

Reset
REQ-022 rst=1 SHALL immediately force IDLE, PC=0, opcode/imm registers=0, instr=0, imm=0, busy=0, halted=0.
REQ-023 rst asserted mid-instruction (any state) SHALL abort with no further instr issue; after release, block waits in IDLE for start.

Configuration
REQ-024 Macro SEQ_SINGLE_STEP_EN, when defined, SHALL add port step (input, 1) and hold FETCH until step=1 in that cycle; each step pulse advances exactly one instruction.
REQ-025 Without SEQ_SINGLE_STEP_EN, port step SHALL not exist and FETCH SHALL last one cycle.

Structure
REQ-026 Shared package seq_pkg SHALL hold the state enumeration, opcode constants (OP_NOP=0x0, OP_JMP=0xE, OP_HALT=0xF) and width constants (OP_W=4, PC_W=4).
REQ-027 PC register with increment/load/clear SHALL be sub-module pc_counter; FSM and decode stay in instr_sequencer.

Verification
REQ-028 Reset then start pulse, program {0x1A,0x27,0xF0} -> instr=1/imm=A, then instr=2/imm=7, each one cycle, 3 cycles apart; then halted=1, busy=0.
REQ-029 Program with 0xE3 at address 1 -> prog_addr sequence 0,1,3; address 2 never fetched.
REQ-030 Sixteen NOP words (0x00) -> PC wraps 15->0, busy stays 1, instr remains 0 throughout.
REQ-031 rst asserted during EXEC of 0x35 -> instr drops to 0 same time, state IDLE; start re-runs from prog_addr=0.
REQ-032 start held high during execution -> no restart; after HALT, start=1 -> prog_addr=0 next cycle and busy=1.
REQ-033 With SEQ_SINGLE_STEP_EN, step pulses every 10 cycles -> exactly one instr issue per pulse, prog_addr stable between pulses.

Source files
------------

// File: rtl/seq_pkg.sv
// seq_pkg: shared state encoding, opcode and width constants for the instruction sequencer
package seq_pkg;
  localparam int OP_W = 4;
  localparam int PC_W = 4;
  localparam logic [OP_W-1:0] OP_NOP  = 4'h0;
  localparam logic [OP_W-1:0] OP_JMP  = 4'hE;
  localparam logic [OP_W-1:0] OP_HALT = 4'hF;
  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, HALT} state_t;
  // NOP and JMP leave the register file alone; HALT never reaches EXEC
  function automatic logic is_issue(input logic [OP_W-1:0] op);
    return op != OP_NOP && op != OP_JMP && op != OP_HALT;
  endfunction
endpackage

// File: rtl/pc_counter.sv
// pc_counter: program counter with clear, load and modulo-2^PC_W increment (clear > load > inc)
module pc_counter
  import seq_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            clear,
  input  logic            load,
  input  logic            inc,
  input  logic [PC_W-1:0] load_val,
  output logic [PC_W-1:0] pc
);
  always_ff @(posedge clk or posedge rst)
    if (rst) pc <= '0;
    else if (clear) pc <= '0;
    else if (load) pc <= load_val;
    else if (inc) pc <= pc + 1'b1;
endmodule

// File: rtl/instr_sequencer.sv
// instr_sequencer: fetch/decode/exec sequencer issuing one instruction every 3 cycles.
// Optional SEQ_SINGLE_STEP_EN adds a step input that gates each FETCH.
module instr_sequencer
  import seq_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
`ifdef SEQ_SINGLE_STEP_EN
  input  logic            step,
`endif
  output logic [PC_W-1:0] prog_addr,
  input  logic [7:0]      prog_data,
  output logic [OP_W-1:0] instr,
  output logic [3:0]      imm,
  output logic            busy,
  output logic            halted
);
  state_t state_q, state_d;
  logic [OP_W-1:0] op_q;
  logic [3:0] imm_q;
  logic pc_clear, pc_load, pc_inc, capture, fetch_go;
`ifdef SEQ_SINGLE_STEP_EN
  assign fetch_go = step;
`else
  assign fetch_go = 1'b1;
`endif
  pc_counter u_pc (
    .clk(clk),
    .rst(rst),
    .clear(pc_clear),
    .load(pc_load),
    .inc(pc_inc),
    .load_val(imm_q),
    .pc(prog_addr)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) state_q <= IDLE;
    else state_q <= state_d;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      op_q  <= OP_NOP;
      imm_q <= '0;
    end else if (capture) begin
      op_q  <= prog_data[7:4];
      imm_q <= prog_data[3:0];
    end
  // start is only looked at in IDLE and HALT, so it is ignored while busy
  always_comb begin
    state_d  = state_q;
    pc_clear = 1'b0;
    pc_load  = 1'b0;
    pc_inc   = 1'b0;
    capture  = 1'b0;
    case (state_q)
      IDLE, HALT: begin
        state_d  = start ? FETCH : state_q;
        pc_clear = start;
      end
      FETCH: begin
        state_d = fetch_go ? DECODE : FETCH;
        capture = fetch_go;
      end
      DECODE: state_d = op_q == OP_HALT ? HALT : EXEC;
      EXEC: begin
        state_d = FETCH;
        pc_load = op_q == OP_JMP;
        pc_inc  = op_q != OP_JMP;
      end
      default: state_d = IDLE;
    endcase
  end
  assign instr  = state_q == EXEC && is_issue(op_q) ? op_q : '0;
  assign imm    = imm_q;
  assign busy   = state_q != IDLE && state_q != HALT;
  assign halted = state_q == HALT;
endmodule
